ptw: RTL

//  Two-level (Sv32-style) page table walker. Serves the TLB's miss requests:

---
 rtl/ptw_pkg.sv | 33 +++
 rtl/ptw_sat_cnt.sv | 28 ++
 rtl/ptw.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/ptw_pkg.sv
// Shared types and helpers for the two-level page table walker.
// State encoding, PTE flag bit positions, PTE classification and
// PTE physical-address formation.
package ptw_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L1_REQ  = 3'd1,
    L1_WAIT = 3'd2,
    L2_REQ  = 3'd3,
    L2_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam int PTE_R = 0;
  localparam int PTE_W = 1;
  localparam int PTE_V = 2;

  // Flags are passed as the low three PTE bits {V,W,R}.
  function automatic logic pte_is_pointer(input logic [2:0] flags);
    return flags[PTE_V] && !flags[PTE_W] && !flags[PTE_R];
  endfunction

  function automatic logic pte_is_leaf(input logic [2:0] flags);
    return flags[PTE_V] && (flags[PTE_W] || flags[PTE_R]);
  endfunction

  // Word address of the PTE selected by a 10-bit VPN inside table page ppn.
  function automatic logic [31:0] pte_addr(input logic [19:0] ppn, input logic [9:0] vpn);
    return {ppn, vpn, 2'b00};
  endfunction

endpackage

// File: rtl/ptw_sat_cnt.sv
// Saturating event counter: counts i_inc pulses, sticks at all-ones.
// Latency: o_cnt reflects an increment one cycle after i_inc.
// Backpressure: none; every i_inc cycle is counted until saturation.
// Ports: clk, rst_n (sync, active-low), i_inc (count enable), o_cnt (count).
module ptw_sat_cnt
  import ptw_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ptw.sv
// Two-level page table walker: vaddr in, two PTE reads, leaf PTE (or 0 on fault) out.
// Latency: 4 edges after accept to resp_valid with zero-wait memory (2 on L1 fault).
// Backpressure: one walk in flight; req_ready low until the response handshake,
//   mem request and walk response are held stable until their ready is seen.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   satp_ppn_i                       root table PPN, used at request accept only
//   ptw_req_valid_i/ready_o, vaddr   walk request from the TLB
//   ptw_resp_valid_o/ready_i, pte_o  walk response (32'h0 means fault)
//   mem_req_valid_o/ready_i, addr_o  PTE read request
//   mem_resp_valid_i/ready_o, rdata_i, err_i   PTE read data
//   walks_o, faults_o                saturating perf counters
module ptw
  import ptw_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [19:0]      satp_ppn_i,
  input  logic             ptw_req_valid_i,
  output logic             ptw_req_ready_o,
  input  logic [31:0]      ptw_vaddr_i,
  output logic             ptw_resp_valid_o,
  input  logic             ptw_resp_ready_i,
  output logic [31:0]      ptw_pte_o,
  output logic             mem_req_valid_o,
  input  logic             mem_req_ready_i,
  output logic [31:0]      mem_addr_o,
  input  logic             mem_resp_valid_i,
  output logic             mem_resp_ready_o,
  input  logic [31:0]      mem_rdata_i,
  input  logic             mem_err_i,
  output logic [CNT_W-1:0] walks_o,
  output logic [CNT_W-1:0] faults_o
);

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_req_ready;
  logic        r_mem_req_valid;
  logic [31:0] r_mem_addr;
  logic        r_mem_resp_ready;
  logic        r_resp_valid;
  logic [31:0] r_pte;
  // Only the level-2 VPN is kept; the L1 address (with satp) is formed at
  // accept, so a later satp change cannot affect the walk.
  logic [9:0]  r_vpn0;

  logic        w_req_ready_nxt;
  logic        w_mem_req_valid_nxt;
  logic [31:0] w_mem_addr_nxt;
  logic        w_mem_resp_ready_nxt;
  logic        w_resp_valid_nxt;
  logic [31:0] w_pte_nxt;
  logic [9:0]  w_vpn0_nxt;

  logic        w_req_fire;
  logic        w_mem_resp_fire;
  logic        w_resp_fire;
  logic        w_l1_fault;
  logic        w_l2_ok;
  logic        w_unused;

  // The page offset takes no part in the walk.
  assign w_unused = &{1'b0, ptw_vaddr_i[11:0]};

  assign w_req_fire      = ptw_req_valid_i && r_req_ready;
  // Responses are only taken while a *_WAIT state holds mem_resp_ready high,
  // so stray data in any other state is dropped.
  assign w_mem_resp_fire = mem_resp_valid_i && r_mem_resp_ready;
  assign w_resp_fire     = r_resp_valid && ptw_resp_ready_i;
  assign w_l1_fault      = mem_err_i || !pte_is_pointer(mem_rdata_i[2:0]);
  assign w_l2_ok         = !mem_err_i && pte_is_leaf(mem_rdata_i[2:0]);

  // Register process: state plus every registered output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_req_ready      <= 1'b1;
      r_mem_req_valid  <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_resp_ready <= 1'b0;
      r_resp_valid     <= 1'b0;
      r_pte            <= '0;
      r_vpn0           <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_req_ready      <= w_req_ready_nxt;
      r_mem_req_valid  <= w_mem_req_valid_nxt;
      r_mem_addr       <= w_mem_addr_nxt;
      r_mem_resp_ready <= w_mem_resp_ready_nxt;
      r_resp_valid     <= w_resp_valid_nxt;
      r_pte            <= w_pte_nxt;
      r_vpn0           <= w_vpn0_nxt;
    end
  end

  // Next-state process.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_req_fire)       w_state_nxt = L1_REQ;
      L1_REQ:  if (mem_req_ready_i)  w_state_nxt = L1_WAIT;
      L1_WAIT: if (w_mem_resp_fire)  w_state_nxt = w_l1_fault ? RESP : L2_REQ;
      L2_REQ:  if (mem_req_ready_i)  w_state_nxt = L2_WAIT;
      L2_WAIT: if (w_mem_resp_fire)  w_state_nxt = RESP;
      RESP:    if (ptw_resp_ready_i) w_state_nxt = IDLE;
      default:                       w_state_nxt = IDLE;
    endcase
  end

  // Output process: next values of the registered outputs.
  always_comb begin
    w_req_ready_nxt      = r_req_ready;
    w_mem_req_valid_nxt  = r_mem_req_valid;
    w_mem_addr_nxt       = r_mem_addr;
    w_mem_resp_ready_nxt = r_mem_resp_ready;
    w_resp_valid_nxt     = r_resp_valid;
    w_pte_nxt            = r_pte;
    w_vpn0_nxt           = r_vpn0;
    case (r_state)
      IDLE: begin
        if (w_req_fire) begin
          w_req_ready_nxt     = 1'b0;
          w_mem_req_valid_nxt = 1'b1;
          w_mem_addr_nxt      = pte_addr(satp_ppn_i, ptw_vaddr_i[31:22]);
          w_vpn0_nxt          = ptw_vaddr_i[21:12];
        end
      end
      L1_REQ, L2_REQ: begin
        if (mem_req_ready_i) begin
          w_mem_req_valid_nxt  = 1'b0;
          w_mem_resp_ready_nxt = 1'b1;
        end
      end
      L1_WAIT: begin
        if (w_mem_resp_fire) begin
          w_mem_resp_ready_nxt = 1'b0;
          if (w_l1_fault) begin
            w_pte_nxt        = '0;
            w_resp_valid_nxt = 1'b1;
          end else begin
            w_mem_req_valid_nxt = 1'b1;
            w_mem_addr_nxt      = pte_addr(mem_rdata_i[31:12], r_vpn0);
          end
        end
      end
      L2_WAIT: begin
        if (w_mem_resp_fire) begin
          w_mem_resp_ready_nxt = 1'b0;
          // A pointer (or anything non-leaf) at the last level is a fault.
          w_pte_nxt            = w_l2_ok ? mem_rdata_i : 32'h0;
          w_resp_valid_nxt     = 1'b1;
        end
      end
      RESP: begin
        if (ptw_resp_ready_i) begin
          w_resp_valid_nxt = 1'b0;
          w_req_ready_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  ptw_sat_cnt #(.CNT_W(CNT_W)) u_walks_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_resp_fire),
    .o_cnt (walks_o)
  );

  ptw_sat_cnt #(.CNT_W(CNT_W)) u_faults_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_resp_fire && (r_pte == 32'h0)),
    .o_cnt (faults_o)
  );

  assign ptw_req_ready_o  = r_req_ready;
  assign mem_req_valid_o  = r_mem_req_valid;
  assign mem_addr_o       = r_mem_addr;
  assign mem_resp_ready_o = r_mem_resp_ready;
  assign ptw_resp_valid_o = r_resp_valid;
  assign ptw_pte_o        = r_pte;

endmodule
